// File: rtl/toggle_counter_pkg.sv
// Shared defaults and direction constants for the toggle_counter block.
// Optional feature macro honoured elsewhere: TOGGLE_COUNTER_SATURATE_EN.
package toggle_counter_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_MODULO = 10;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Terminal-count rule shared by the counter and anyone modelling it.
   function automatic logic term_count(input logic up, input logic is_max, input logic is_zero);
      return (up == DIR_UP) ? is_max : is_zero;
   endfunction

endpackage

// File: rtl/toggle_counter_if.sv
// Control/status bundle of toggle_counter: master drives the controls, slave owns q/tc/co.
interface toggle_counter_if
   import toggle_counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             co;

   modport master (output en, output up, output load, output d,
                   input  q,  input  tc, input  co);

   modport slave  (input  en, input  up, input  load, input  d,
                   output q,  output tc, output co);
endinterface

// File: rtl/toggle_cell.sv
// Single T flip-flop holding one counter bit; clears asynchronously on re low.
module toggle_cell (
   input  logic clk,
   input  logic re,
   input  logic t,
   output logic q
);
   logic r_q;

   // Toggle storage with asynchronous active-low clear.
   always_ff @(posedge clk or negedge re) begin
      if (!re) begin
         r_q <= 1'b0;
      end else begin
         r_q <= r_q ^ t;
      end
   end

   assign q = r_q;
endmodule

// File: rtl/toggle_counter.sv
// Modulo-N up/down counter built from toggle cells: next-state/toggle vector, tc, co register.
// Define TOGGLE_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module toggle_counter
   import toggle_counter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int MODULO = DEF_MODULO
) (
   input  logic          clk,
   input  logic          re,
   toggle_counter_if.slave bus
);
   localparam logic [WIDTH:0]   L_MOD  = (WIDTH+1)'(MODULO);
   localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] L_ZERO = '0;
   localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_t;
   logic             w_tc;
   logic             w_illegal;
   logic             r_co;

   assign w_illegal = ({1'b0, w_q} >= L_MOD);
   assign w_tc      = term_count(bus.up, (w_q == L_MAX), (w_q == L_ZERO));

   // Next count: load beats count beats hold; out-of-range states recover on the next count.
   always_comb begin
      w_next = w_q;
      if (bus.load) begin
         if ({1'b0, bus.d} < L_MOD) begin
            w_next = bus.d;
         end else begin
            w_next = L_ZERO;
         end
      end else if (bus.en) begin
`ifdef TOGGLE_COUNTER_SATURATE_EN
         if (w_illegal) begin
            w_next = L_MAX;
         end else if (bus.up == DIR_UP) begin
            w_next = (w_q == L_MAX) ? L_MAX : (w_q + L_ONE);
         end else begin
            w_next = (w_q == L_ZERO) ? L_ZERO : (w_q - L_ONE);
         end
`else
         if (w_illegal) begin
            w_next = L_ZERO;
         end else if (bus.up == DIR_UP) begin
            w_next = (w_q == L_MAX) ? L_ZERO : (w_q + L_ONE);
         end else begin
            w_next = (w_q == L_ZERO) ? L_MAX : (w_q - L_ONE);
         end
`endif
      end else begin
         w_next = w_q;
      end
   end

   assign w_t = w_q ^ w_next;

   genvar g_i;
   generate
      for (g_i = 0; g_i < WIDTH; g_i++) begin : g_cell
         toggle_cell u_cell (
            .clk (clk),
            .re  (re),
            .t   (w_t[g_i]),
            .q   (w_q[g_i])
         );
      end
   endgenerate

   // Carry/borrow pulse: registered copy of an enabled count taken at the terminal value.
   always_ff @(posedge clk or negedge re) begin
      if (!re) begin
         r_co <= 1'b0;
      end else begin
         r_co <= bus.en & ~bus.load & w_tc;
      end
   end

   assign bus.q  = w_q;
   assign bus.tc = w_tc;
   assign bus.co = r_co;
endmodule
